uart_rx: RTL and testbench

//  8N1 UART receiver, directly downstream of the baud generator.
//  - Consumes the 16x oversample clock (clk_baud_sample) as a rising-edge tick enable only; all logic runs on clk.
//  - Recovers bytes from the serial rx line and presents each on data with a one-cycle data_valid strobe.
//  - Flags bad stop bits with a one-cycle frame_err strobe.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Output bundle of the 8N1 UART receiver.
// The receiver drives the master side; consumers take the slave side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// The baud sample wave is only used as a rising-edge tick enable on clk.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clk_baud_sample,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_MID =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END =
    TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST =
    BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sample_d;
  logic                   tick;
  logic                   rx_s;

  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_q;
  logic                 valid_nxt;
  logic                 err_q;
  logic                 err_nxt;

  // Preset to 1 so neither a false start nor a
  // false tick appears right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '1;
      sample_d <= 1'b1;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], rx};
      sample_d <= clk_baud_sample;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign tick = clk_baud_sample & ~sample_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == T_MID) begin
            tick_nxt = '0;
            if (!rx_s) begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == T_END) begin
            tick_nxt  = '0;
            shift_nxt =
              {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == B_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == T_END) begin
            tick_nxt = '0;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = WAIT_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 55-clk tick, 880-clk bit.
// A negedge monitor counts strobes; checks compare snapshots.
module tb_uart_rx;

  localparam int BIT_T = 880;

  logic clk;
  logic rst;
  logic baud;
  logic rx;
  int   bcnt;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_baud_sample(baud),
    .rx             (rx),
    .bus            (bus)
  );

  int n_chk;
  int n_pass;

  int       dv_cnt;
  int       fe_cnt;
  int       both_cnt;
  int       busy_cnt;
  int       noisy_cnt;
  logic [7:0] last_d;
  logic [7:0] prev_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bcnt == 54) bcnt = 0;
      else bcnt++;
      baud = (bcnt < 27);
    end
  end

  initial begin
    dv_cnt    = 0;
    fe_cnt    = 0;
    both_cnt  = 0;
    busy_cnt  = 0;
    noisy_cnt = 0;
    last_d    = 8'h00;
    prev_d    = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.data_valid) begin
        dv_cnt++;
        prev_d = last_d;
        last_d = bus.data;
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.data_valid && bus.frame_err)
        both_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.data != 8'h00 || bus.data_valid ||
          bus.frame_err || bus.busy)
        noisy_cnt++;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       stop
  );
    hold(1'b0, BIT_T);
    for (int i = 0; i < 8; i++)
      hold(b[i], BIT_T);
    hold(stop, BIT_T);
  endtask

  int dv0;
  int fe0;
  int bz0;
  int nz0;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_data", bus.data, 8'h00);
    check("rst_valid", bus.data_valid, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);

    nz0 = noisy_cnt;
    hold(1'b1, 200);
    @(negedge clk);
    check("idle_quiet", noisy_cnt - nz0, 0);

    // Frame 0xA5 with good stop bit
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, BIT_T);
    @(negedge clk);
    check("a5_pulses", dv_cnt - dv0, 1);
    check("a5_data", bus.data, 8'hA5);
    check("a5_last", last_d, 8'hA5);
    check("a5_err", fe_cnt - fe0, 0);
    check("a5_busy", bus.busy, 0);

    // Short low glitch: 3 ticks
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    bz0 = busy_cnt;
    hold(1'b0, 165);
    hold(1'b1, 1200);
    @(negedge clk);
    check("gl_valid", dv_cnt - dv0, 0);
    check("gl_err", fe_cnt - fe0, 0);
    check("gl_busy_seen",
          32'(busy_cnt != bz0), 1);
    check("gl_busy_end", bus.busy, 0);
    check("gl_data", bus.data, 8'hA5);

    // Bad stop bit, then line held low
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0);
    hold(1'b0, 3000);
    @(negedge clk);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_valid", dv_cnt - dv0, 0);
    check("fe_data", bus.data, 8'hA5);
    check("fe_busy_low", bus.busy, 1);
    hold(1'b1, 1000);
    @(negedge clk);
    check("fe_busy_rel", bus.busy, 0);

    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1);
    hold(1'b1, BIT_T);
    @(negedge clk);
    check("rec_pulses", dv_cnt - dv0, 1);
    check("rec_data", bus.data, 8'h3C);

    // Back-to-back frames, no idle gap
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, BIT_T);
    @(negedge clk);
    check("b2b_pulses", dv_cnt - dv0, 2);
    check("b2b_first", prev_d, 8'h55);
    check("b2b_second", last_d, 8'hFF);
    check("b2b_err", fe_cnt - fe0, 0);

    // Reset during data bit 4 of 0xF0
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    hold(1'b0, BIT_T);
    for (int i = 0; i < 4; i++)
      hold(1'b0, BIT_T);
    hold(1'b1, BIT_T / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ab_data", bus.data, 8'h00);
    check("ab_valid", bus.data_valid, 0);
    check("ab_err", bus.frame_err, 0);
    check("ab_busy", bus.busy, 0);
    hold(1'b1, BIT_T / 2 + 4 * BIT_T);
    hold(1'b1, BIT_T);
    @(negedge clk);
    check("ab_no_pulse", dv_cnt - dv0, 0);
    check("ab_no_err", fe_cnt - fe0, 0);

    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1);
    hold(1'b1, BIT_T);
    @(negedge clk);
    check("post_pulses", dv_cnt - dv0, 1);
    check("post_data", bus.data, 8'h3C);

    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
